// File: rtl/canvas_sequencer.sv
// Canvas / MNIST sequencer: gates drawing, issues clears, streams the canvas row-major, latches the NN digit.
// Optional build macro SEQ_TIMEOUT_EN adds a WAIT_NN watchdog. Canvas_In packs cell [x][y] at bits (x*ROWS+y)*DW.
module canvas_sequencer #(
  parameter int ROWS           = 28,
  parameter int COLS           = 28,
  parameter int DW             = 16,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Clear_Req,
  input  logic [DW*COLS*ROWS-1:0] Canvas_In,
  output logic                   Draw_En,
  output logic                   Canvas_Clr,
  output logic [DW-1:0]          Pix_Data,
  output logic [9:0]             Pix_Index,
  output logic                   Pix_Valid,
  output logic                   Pix_Last,
  input  logic                   Pix_Ready,
  input  logic                   NN_Done,
  input  logic [3:0]             NN_Digit,
  output logic [3:0]             Digit_Out,
  output logic                   Digit_Valid,
  output logic                   Busy,
  output logic                   Timeout_Flag
);

  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);
  localparam int CW   = $clog2(CLR_CYCLES + 1);
  localparam int NPIX = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_STREAM  = 2'd2,
    S_WAIT_NN = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [XW-1:0]  r_x_cnt;
  logic [YW-1:0]  r_y_cnt;
  logic [CW-1:0]  r_clr_cnt;
  logic [3:0]     r_digit;
  logic           r_digit_valid;

  logic           w_xfer;
  logic           w_last;
  logic           w_clr_done;
  logic           w_timeout;
  logic           w_wd_fire;
  logic           w_nn_accept;
  logic           w_enter_clear;
  logic           w_enter_stream;
  logic [31:0]    w_cell_base;

  // Pixel path is purely a decode of the registered counters, so it cannot move while Pix_Ready is low.
  assign w_cell_base = (32'(r_x_cnt) * 32'(ROWS) + 32'(r_y_cnt)) * 32'(DW);
  assign Pix_Data    = Canvas_In[w_cell_base +: DW];
  assign Pix_Index   = 10'(32'(r_y_cnt) * 32'(COLS) + 32'(r_x_cnt));
  assign w_last      = (Pix_Index == 10'(NPIX - 1));
  assign Pix_Last    = w_last && (r_state == S_STREAM);

  assign w_xfer         = (r_state == S_STREAM) && Pix_Ready;
  assign w_clr_done     = (r_clr_cnt == CW'(CLR_CYCLES - 1));
  assign w_nn_accept    = (r_state == S_WAIT_NN) && NN_Done && !Clear_Req;
  assign w_wd_fire      = w_timeout && !NN_Done && !Clear_Req;
  assign w_enter_clear  = (w_state_next == S_CLEAR)  && (r_state != S_CLEAR);
  assign w_enter_stream = (w_state_next == S_STREAM) && (r_state != S_STREAM);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    Draw_En      = 1'b0;
    Canvas_Clr   = 1'b0;
    Pix_Valid    = 1'b0;
    Busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        Draw_En = 1'b1;
        Busy    = 1'b0;
        if (Clear_Req) begin
          w_state_next = S_CLEAR;
        end else if (Start) begin
          w_state_next = S_STREAM;
        end
      end
      S_CLEAR: begin
        Canvas_Clr = 1'b1;
        if (w_clr_done) begin
          w_state_next = S_IDLE;
        end
      end
      S_STREAM: begin
        Pix_Valid = 1'b1;
        if (Clear_Req) begin
          w_state_next = S_CLEAR;
        end else if (w_xfer && w_last) begin
          w_state_next = S_WAIT_NN;
        end
      end
      S_WAIT_NN: begin
        if (Clear_Req) begin
          w_state_next = S_CLEAR;
        end else if (NN_Done || w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Counters are held at zero outside STREAM, so every stream starts at pixel 0 and aborts need no extra path.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else if (w_state_next != S_STREAM) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else if (w_xfer) begin
      if (r_x_cnt == XW'(COLS - 1)) begin
        r_x_cnt <= '0;
        r_y_cnt <= r_y_cnt + 1'b1;
      end else begin
        r_x_cnt <= r_x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clr_cnt <= '0;
    end else if ((r_state == S_CLEAR) && (w_state_next == S_CLEAR)) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end else begin
      r_clr_cnt <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_digit       <= 4'h0;
      r_digit_valid <= 1'b0;
    end else if (w_enter_clear || w_enter_stream) begin
      r_digit_valid <= 1'b0;
    end else if (w_nn_accept) begin
      r_digit       <= NN_Digit;
      r_digit_valid <= 1'b1;
    end else if (w_wd_fire) begin
      r_digit       <= 4'hF;
      r_digit_valid <= 1'b1;
    end
  end

  assign Digit_Out   = r_digit;
  assign Digit_Valid = r_digit_valid;

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] r_wd_cnt;
  logic          r_timeout_flag;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT_NN) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT_NN) && (r_wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_timeout_flag <= 1'b0;
    end else if (w_enter_clear || w_nn_accept) begin
      r_timeout_flag <= 1'b0;
    end else if (w_wd_fire) begin
      r_timeout_flag <= 1'b1;
    end
  end

  assign Timeout_Flag = r_timeout_flag;
`else
  assign w_timeout    = 1'b0;
  assign Timeout_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_canvas_sequencer.sv
// Self-checking bench for canvas_sequencer: random backpressure and canvas data against a row-major pixel model.
// Watchdog scenario runs only when SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES=50 here).
module tb_canvas_sequencer;
  localparam int ROWS = 28;
  localparam int COLS = 28;
  localparam int DW   = 16;
  localparam int NPIX = ROWS * COLS;
  localparam int TOUT = 50;

  logic                    Clk;
  logic                    Reset;
  logic                    Start;
  logic                    Clear_Req;
  logic [DW*COLS*ROWS-1:0] Canvas_In;
  logic                    Draw_En;
  logic                    Canvas_Clr;
  logic [DW-1:0]           Pix_Data;
  logic [9:0]              Pix_Index;
  logic                    Pix_Valid;
  logic                    Pix_Last;
  logic                    Pix_Ready;
  logic                    NN_Done;
  logic [3:0]              NN_Digit;
  logic [3:0]              Digit_Out;
  logic                    Digit_Valid;
  logic                    Busy;
  logic                    Timeout_Flag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] canvas  [COLS][ROWS];
  logic [DW-1:0] exp_pix [NPIX];

  canvas_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .DW(DW), .CLR_CYCLES(2), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Clear_Req(Clear_Req), .Canvas_In(Canvas_In),
    .Draw_En(Draw_En), .Canvas_Clr(Canvas_Clr), .Pix_Data(Pix_Data), .Pix_Index(Pix_Index),
    .Pix_Valid(Pix_Valid), .Pix_Last(Pix_Last), .Pix_Ready(Pix_Ready), .NN_Done(NN_Done),
    .NN_Digit(NN_Digit), .Digit_Out(Digit_Out), .Digit_Valid(Digit_Valid), .Busy(Busy),
    .Timeout_Flag(Timeout_Flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Canvas cell [x][y] lives at bit offset (x*ROWS+y)*DW; the stream visits cells row-major (y outer, x inner).
  task automatic load_canvas(input bit random_fill);
    for (int x = 0; x < COLS; x++) begin
      for (int y = 0; y < ROWS; y++) begin
        canvas[x][y] = random_fill ? DW'($urandom) : DW'(y * COLS + x);
        Canvas_In[(x*ROWS+y)*DW +: DW] = canvas[x][y];
      end
    end
    for (int i = 0; i < NPIX; i++) exp_pix[i] = canvas[i % COLS][i / COLS];
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic pulse_nn(input logic [3:0] dig);
    NN_Digit = dig;
    NN_Done  = 1'b1;
    tick();
    NN_Done  = 1'b0;
  endtask

  // Offers pixels from index k0 until index k1 has been reached; the pixel at k1 stays offered but untransferred.
  task automatic drive_stream(input bit rand_ready, input int k0, input int k1, output int cycles);
    int k;
    k = k0;
    cycles = 0;
    while (k < k1 && cycles < 20000) begin
      Pix_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n_checks++;
      if (Pix_Valid !== 1'b1 || Draw_En !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_ctrl k=%0d got valid=%b draw=%b want valid=1 draw=0", k, Pix_Valid, Draw_En);
      end
      n_checks++;
      if (Pix_Index !== 10'(k)) begin
        n_fail++;
        $display("FAIL stream_index got %0d want %0d", Pix_Index, k);
      end
      n_checks++;
      if (Pix_Data !== exp_pix[k]) begin
        n_fail++;
        $display("FAIL stream_data k=%0d got %h want %h", k, Pix_Data, exp_pix[k]);
      end
      n_checks++;
      if (Pix_Last !== (k == NPIX - 1)) begin
        n_fail++;
        $display("FAIL stream_last k=%0d got %b want %b", k, Pix_Last, (k == NPIX - 1));
      end
      if (Pix_Ready) k++;
      cycles++;
      tick();
    end
    Pix_Ready = 1'b0;
    n_checks++;
    if (k != k1) begin
      n_fail++;
      $display("FAIL stream_budget got index %0d want %0d", k, k1);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    n_checks++;
    if ({Draw_En, Busy, Pix_Valid, Digit_Valid, Canvas_Clr, Pix_Last, Timeout_Flag} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl got draw/busy/valid/dvalid/clr/last/tout=%b want 1000000",
               {Draw_En, Busy, Pix_Valid, Digit_Valid, Canvas_Clr, Pix_Last, Timeout_Flag});
    end
    n_checks++;
    if (Digit_Out !== 4'h0 || Pix_Index !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_regs got digit=%h index=%0d want 0 0", Digit_Out, Pix_Index);
    end
    $display("reset: draw=%b busy=%b", Draw_En, Busy);
  endtask

  task automatic test_full_stream();
    int cyc;
    load_canvas(1'b0);
    pulse_start();
    drive_stream(1'b0, 0, NPIX, cyc);
    n_checks++;
    if (cyc != NPIX) begin
      n_fail++;
      $display("FAIL full_stream_cycles got %0d want %0d", cyc, NPIX);
    end
    repeat (5) tick();
    n_checks++;
    if (Busy !== 1'b1 || Pix_Valid !== 1'b0 || Draw_En !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_nn_hold got busy=%b valid=%b draw=%b want 1 0 0", Busy, Pix_Valid, Draw_En);
    end
    $display("full stream: %0d pixels in %0d cycles", NPIX, cyc);
  endtask

  task automatic test_result();
    pulse_nn(4'd7);
    n_checks++;
    if (Digit_Out !== 4'd7 || Digit_Valid !== 1'b1 || Busy !== 1'b0 || Timeout_Flag !== 1'b0) begin
      n_fail++;
      $display("FAIL result_latch got digit=%0d dvalid=%b busy=%b tout=%b want 7 1 0 0",
               Digit_Out, Digit_Valid, Busy, Timeout_Flag);
    end
    pulse_nn(4'd3);
    tick();
    n_checks++;
    if (Digit_Out !== 4'd7 || Digit_Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_idle_nn got digit=%0d dvalid=%b want 7 1", Digit_Out, Digit_Valid);
    end
    $display("result: digit=%0d valid=%b", Digit_Out, Digit_Valid);
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [3:0] dig;
    load_canvas(1'b1);
    pulse_start();
    n_checks++;
    if (Digit_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears_valid got %b want 0", Digit_Valid);
    end
    drive_stream(1'b1, 0, NPIX, cyc);
    // Start while waiting on the NN must not restart the stream.
    pulse_start();
    repeat ($urandom_range(0, 10)) tick();
    n_checks++;
    if (Pix_Valid !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored got valid=%b busy=%b want 0 1", Pix_Valid, Busy);
    end
    dig = 4'($urandom_range(0, 14));
    pulse_nn(dig);
    n_checks++;
    if (Digit_Out !== dig || Digit_Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_result got digit=%0d dvalid=%b want %0d 1", Digit_Out, Digit_Valid, dig);
    end
    $display("backpressure stream: %0d cycles, digit=%0d", cyc, Digit_Out);
  endtask

  task automatic test_abort();
    int cyc;
    pulse_start();
    drive_stream(1'b0, 0, 100, cyc);
    Start    = 1'b1;
    NN_Digit = 4'd9;
    NN_Done  = 1'b1;
    tick();
    Start   = 1'b0;
    NN_Done = 1'b0;
    n_checks++;
    if (Pix_Index !== 10'd100 || Pix_Valid !== 1'b1 || Digit_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_ignores got index=%0d valid=%b dvalid=%b want 100 1 0", Pix_Index, Pix_Valid, Digit_Valid);
    end
    drive_stream(1'b1, 100, 300, cyc);
    Clear_Req = 1'b1;
    Pix_Ready = 1'b1;
    tick();
    Clear_Req = 1'b0;
    Pix_Ready = 1'b0;
    n_checks++;
    if (Pix_Valid !== 1'b0 || Canvas_Clr !== 1'b1 || Draw_En !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_first got valid=%b clr=%b draw=%b want 0 1 0", Pix_Valid, Canvas_Clr, Draw_En);
    end
    tick();
    n_checks++;
    if (Canvas_Clr !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_clr2 got %b want 1", Canvas_Clr);
    end
    tick();
    n_checks++;
    if (Canvas_Clr !== 1'b0 || Busy !== 1'b0 || Draw_En !== 1'b1 || Pix_Index !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_done got clr=%b busy=%b draw=%b index=%0d want 0 0 1 0",
               Canvas_Clr, Busy, Draw_En, Pix_Index);
    end
    $display("abort at pixel 300: canvas cleared, idle");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0] dig;
    for (int f = 0; f < 2; f++) begin
      load_canvas(1'b1);
      pulse_start();
      drive_stream(1'b0, 0, NPIX, cyc);
      dig = 4'($urandom_range(0, 14));
      pulse_nn(dig);
      n_checks++;
      if (Digit_Out !== dig || Digit_Valid !== 1'b1 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_result frame=%0d got digit=%0d dvalid=%b busy=%b want %0d 1 0",
                 f, Digit_Out, Digit_Valid, Busy, dig);
      end
      $display("back-to-back frame %0d: %0d cycles, digit=%0d", f, cyc, Digit_Out);
    end
  endtask

  task automatic test_priority();
    Start     = 1'b1;
    Clear_Req = 1'b1;
    tick();
    n_checks++;
    if (Canvas_Clr !== 1'b1 || Pix_Valid !== 1'b0 || Digit_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_enter got clr=%b valid=%b dvalid=%b want 1 0 0", Canvas_Clr, Pix_Valid, Digit_Valid);
    end
    tick();
    Start     = 1'b0;
    Clear_Req = 1'b0;
    n_checks++;
    if (Canvas_Clr !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_clr2 got %b want 1", Canvas_Clr);
    end
    tick();
    n_checks++;
    if (Canvas_Clr !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_no_restart got clr=%b busy=%b want 0 0", Canvas_Clr, Busy);
    end
    tick();
    n_checks++;
    if (Pix_Valid !== 1'b0 || Draw_En !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_start_dropped got valid=%b draw=%b want 0 1", Pix_Valid, Draw_En);
    end
    $display("start+clear together: clear only");
  endtask

  task automatic test_watchdog();
    int cyc;
    load_canvas(1'b0);
    pulse_start();
    drive_stream(1'b0, 0, NPIX, cyc);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 1; i < TOUT; i++) begin
      tick();
      n_checks++;
      if (Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wd_early cycle=%0d got busy=%b want 1", i, Busy);
      end
    end
    tick();
    n_checks++;
    if (Digit_Out !== 4'hF || Digit_Valid !== 1'b1 || Timeout_Flag !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fire got digit=%h dvalid=%b tout=%b busy=%b want f 1 1 0",
               Digit_Out, Digit_Valid, Timeout_Flag, Busy);
    end
    pulse_start();
    drive_stream(1'b0, 0, NPIX, cyc);
    pulse_nn(4'd5);
    n_checks++;
    if (Digit_Out !== 4'd5 || Timeout_Flag !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_recover got digit=%0d tout=%b want 5 0", Digit_Out, Timeout_Flag);
    end
`else
    repeat (200) tick();
    n_checks++;
    if (Busy !== 1'b1 || Timeout_Flag !== 1'b0 || Digit_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_wd_wait got busy=%b tout=%b dvalid=%b want 1 0 0", Busy, Timeout_Flag, Digit_Valid);
    end
    pulse_nn(4'd5);
    n_checks++;
    if (Digit_Out !== 4'd5 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_wd_result got digit=%0d busy=%b want 5 0", Digit_Out, Busy);
    end
`endif
    $display("wait_nn/watchdog: digit=%h tout=%b", Digit_Out, Timeout_Flag);
  endtask

  task automatic test_reset_midstream();
    int cyc;
    pulse_start();
    drive_stream(1'b0, 0, 10, cyc);
    Reset     = 1'b1;
    Pix_Ready = 1'b1;
    tick();
    Pix_Ready = 1'b0;
    n_checks++;
    if (Pix_Valid !== 1'b0 || Draw_En !== 1'b1 || Digit_Out !== 4'h0 || Digit_Valid !== 1'b0 || Pix_Index !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_abort got valid=%b draw=%b digit=%h dvalid=%b index=%0d want 0 1 0 0 0",
               Pix_Valid, Draw_En, Digit_Out, Digit_Valid, Pix_Index);
    end
    Reset = 1'b0;
    tick();
    n_checks++;
    if (Pix_Valid !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got valid=%b busy=%b want 0 0", Pix_Valid, Busy);
    end
    $display("reset mid-stream: idle");
  endtask

  initial begin
    Reset     = 1'b1;
    Start     = 1'b0;
    Clear_Req = 1'b0;
    Pix_Ready = 1'b0;
    NN_Done   = 1'b0;
    NN_Digit  = 4'h0;
    Canvas_In = '0;
    test_reset();
    test_full_stream();
    test_result();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_priority();
    test_watchdog();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/canvas_sequencer.md
Name: canvas_sequencer

Overview:
- Top-level controller for the 28x28 drawing canvas and the MNIST inference engine.
- Gates drawing into the canvas editor and issues canvas clears.
- On Start, streams all 784 canvas cells, row-major, over a valid/ready pixel interface to the NN input loader.
- Waits for the NN result, then latches the recognised digit for display.

Parameters:
- ROWS, 28, canvas height in cells (Y dimension)
- COLS, 28, canvas width in cells (X dimension)
- DW, 16, canvas cell / pixel data width
- CLR_CYCLES, 2, number of cycles Canvas_Clr is held high per clear
- TIMEOUT_CYCLES, 1000000, WAIT_NN watchdog limit (used only with SEQ_TIMEOUT_EN)

Ports:
- Clk  input  1  system clock; all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request classification; single-cycle pulse, level tolerated
- Clear_Req  input  1  request canvas clear; single-cycle pulse, level tolerated
- Canvas_In  input  DW x COLS x ROWS  canvas cells, indexed [X][Y], from canvas editor
- Draw_En  output  1  drives canvas editor Run; drawing permitted
- Canvas_Clr  output  1  OR'd into canvas editor Reset
- Pix_Data  output  DW  current pixel = Canvas_In[X_cnt][Y_cnt]
- Pix_Index  output  10  linear index Y_cnt*COLS + X_cnt
- Pix_Valid  output  1  pixel offered
- Pix_Last  output  1  high with the final pixel (index 783)
- Pix_Ready  input  1  NN loader accepts pixel
- NN_Done  input  1  single-cycle pulse, result valid
- NN_Digit  input  4  NN argmax result, sampled with NN_Done
- Digit_Out  output  4  latched result
- Digit_Valid  output  1  Digit_Out holds a fresh result
- Busy  output  1  high in CLEAR, STREAM and WAIT_NN
- Timeout_Flag  output  1  last result ended by watchdog; tied 0 without SEQ_TIMEOUT_EN

Behaviour:
- Reset:
  - state=IDLE; X_cnt=Y_cnt=0; clear counter=0; Digit_Out=0; Digit_Valid=0; Timeout_Flag=0.
  - Control outputs are decodes of the state register. In the cycle after Reset: Draw_En=1; Canvas_Clr, Pix_Valid, Pix_Last and Busy all 0.
  - Reset mid-operation aborts immediately. No further pixel is offered after the reset edge.
- IDLE:
  - Draw_En=1.
  - Clear_Req -> CLEAR.
  - Start (with Clear_Req=0) -> STREAM. On entry X_cnt=Y_cnt=0 and Digit_Valid is cleared.
  - If Clear_Req and Start are high in the same cycle, Clear_Req wins and Start is dropped.
- CLEAR:
  - Canvas_Clr=1 for exactly CLR_CYCLES cycles, then return to IDLE. Draw_En=0.
  - Digit_Valid and Timeout_Flag are cleared on entry.
  - Start is ignored. A Clear_Req arriving while in CLEAR does not restart the count.
- STREAM:
  - Pix_Valid=1 and Draw_En=0, so the canvas is frozen.
  - Transfer occurs on Pix_Valid && Pix_Ready.
  - On each transfer, X_cnt increments. At X_cnt=COLS-1 it wraps to 0 and Y_cnt increments.
  - Pix_Data, Pix_Index and Pix_Last must stay stable while Pix_Ready=0. Pix_Data is a combinational mux of the registered counters.
  - Pix_Last=1 exactly when Pix_Index=ROWS*COLS-1.
  - A transfer with Pix_Last -> WAIT_NN. Pix_Valid drops in the next cycle.
  - Back-to-back transfers sustain 1 pixel/cycle. The minimum stream is 784 cycles.
- WAIT_NN:
  - Pix_Valid=0; Draw_En=0.
  - NN_Done: Digit_Out<=NN_Digit, Digit_Valid<=1, Timeout_Flag<=0, then -> IDLE.
  - Digit_Valid holds until the next Start, Clear_Req or Reset.
- Abort and ignore rules:
  - Clear_Req in STREAM or WAIT_NN aborts to CLEAR. Counters reset and Pix_Valid drops the next cycle.
  - Start while Busy is ignored.
  - NN_Done outside WAIT_NN is ignored.
- Counter widths: X_cnt and Y_cnt are $clog2 of COLS and ROWS respectively. Pix_Index is computed at 10 bits.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - A cycle counter is cleared on entry to WAIT_NN and increments every cycle in WAIT_NN.
  - If it reaches TIMEOUT_CYCLES without NN_Done, the block goes to IDLE with Digit_Out=4'hF, Digit_Valid=1 and Timeout_Flag=1.
  - If NN_Done arrives in the same cycle as the timeout, NN_Done wins.
- When undefined:
  - No counter logic exists; WAIT_NN waits indefinitely.
  - Timeout_Flag is constant 0 and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
1. Reset then idle:
   - Stimulus: Reset high 2 cycles, then low.
   - Required: Draw_En=1, Busy=0, Pix_Valid=0, Digit_Valid=0, Canvas_Clr=0.
2. Full stream, Pix_Ready tied 1:
   - Stimulus: Canvas_In[x][y]=y*28+x; pulse Start.
   - Required: exactly 784 consecutive transfers with Pix_Data=Pix_Index=0..783, Pix_Last only at 783, Draw_En=0 throughout, then Busy stays 1 (WAIT_NN).
3. Backpressure:
   - Stimulus: toggle Pix_Ready randomly, 50%.
   - Required: no pixel dropped or duplicated; outputs stable while Ready=0; sequence still 0..783.
4. Result latch:
   - Stimulus: after the stream, pulse NN_Done with NN_Digit=7; then pulse NN_Done again with NN_Digit=3 while in IDLE.
   - Required: Digit_Out=7, Digit_Valid=1, Busy=0; Digit_Out stays 7 after the second pulse.
5. Abort and priority:
   - Stimulus: Clear_Req at pixel 300; then Start and Clear_Req together in IDLE.
   - Required: Pix_Valid=0 next cycle, Canvas_Clr high exactly 2 cycles, back to IDLE with counters at 0; the simultaneous Start is dropped and only CLEAR occurs.
6. Watchdog (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50):
   - Stimulus: complete the stream, never pulse NN_Done.
   - Required: 50 cycles after entering WAIT_NN, Digit_Out=4'hF, Digit_Valid=1, Timeout_Flag=1, state IDLE.
